// File: rtl/invfact_pkg.sv
// Shared types and default widths for the sequential inverse-factorial block.
package invfact_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned N_W_DEF    = 4;
    localparam int unsigned ACC_W_DEF  = DATA_W_DEF + N_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : invfact_pkg

// File: rtl/inverse_factorial_seq.sv
// inverse_factorial_seq: finds n with n! == V by multiplying up one factor per clock.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   V is valid (producer holds until accepted)
//   in_ready   out  block can accept V (high only when idle)
//   in_value   in   DATA_W-bit value V
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts result
//   res_n      out  n when exact; inexact result is 0, or floor n with INVFACT_FLOOR_EN
//   res_exact  out  1 when V is exactly n!
//
// Build option: define INVFACT_FLOOR_EN to report the largest n with n! < V on
// inexact results instead of 0.
module inverse_factorial_seq
    import invfact_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_W    = N_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_W-1:0]    res_n,
    output logic              res_exact
);

    localparam int unsigned ACC_W = DATA_W + N_W;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  v_q, v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]     k_q, k_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [N_W-1:0]     res_n_q, res_n_d;
    logic               res_exact_q, res_exact_d;

    logic [N_W-1:0]     k_inc;
    logic [ACC_W-1:0]   v_ext;
    logic [ACC_W-1:0]   acc_mul;
    logic [N_W-1:0]     inexact_n;

    // acc <= V before every multiply and k+1 < 2^N_W, so the product fits ACC_W.
    assign k_inc   = k_q + N_W'(1);
    assign v_ext   = ACC_W'(v_q);
    assign acc_mul = acc_q * ACC_W'(k_inc);

`ifdef INVFACT_FLOOR_EN
    // Overshoot at k means (k-1)! < V < k!; k is at least 1 here.
    assign inexact_n = k_q - N_W'(1);
`else
    assign inexact_n = '0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_n_q     <= '0;
            res_exact_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_n_q     <= res_n_d;
            res_exact_q <= res_exact_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        acc_d       = acc_q;
        k_d         = k_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        res_n_d     = res_n_q;
        res_exact_d = res_exact_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    v_d        = in_value;
                    acc_d      = ACC_W'(1);
                    k_d        = N_W'(1);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (acc_q == v_ext) begin
                    res_n_d     = k_q;
                    res_exact_d = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (acc_q > v_ext) begin
                    res_n_d     = inexact_n;
                    res_exact_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d   = k_inc;
                    acc_d = acc_mul;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res_n     = res_n_q;
    assign res_exact = res_exact_q;

endmodule : inverse_factorial_seq

// File: tb/tb_inverse_factorial_seq.sv
// Self-checking bench for inverse_factorial_seq (default 16/4 widths).
module tb_inverse_factorial_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  res_n;
    logic        res_exact;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef INVFACT_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
    localparam int F3 = 2, F100 = 4, F65535 = 8;
`else
    localparam bit FLOOR_EN = 1'b0;
    localparam int F3 = 0, F100 = 0, F65535 = 0;
`endif

    inverse_factorial_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_n    (res_n),
        .res_exact(res_exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: search factorials directly. Latency is the number of factors tried.
    task automatic model(input longint v, output int n, output int x, output int lat);
        longint f;
        int fl;
        f  = 1;
        fl = 0;
        n  = 0;
        x  = 0;
        for (int i = 1; i < 16; i++) begin
            f = f * i;
            if (f == v && x == 0) begin
                x = 1;
                n = i;
            end
            if (f < v) fl = i;
        end
        lat = (x == 1) ? n : fl + 1;
        if (x == 0) n = FLOOR_EN ? fl : 0;
    endtask

    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
    int m_phase, m_cnt, m_n, m_x, m_fresh;
    int p_n, p_x, p_lat;

    // Transaction-level model: idle -> busy for 'lat' clocks -> done until out_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_cnt   = 0;
            m_n     = 0;
            m_x     = 0;
            m_fresh = 1;
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    model(longint'(in_value), p_n, p_x, p_lat);
                    m_cnt   = p_lat;
                    m_phase = M_BUSY;
                end
                M_BUSY: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = M_DONE;
                        m_n     = p_n;
                        m_x     = p_x;
                        m_fresh = 0;
                    end
                end
                M_DONE: if (out_ready) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_in_ready", longint'(in_ready), longint'(m_phase == M_IDLE));
            chk("mdl_out_valid", longint'(out_valid), longint'(m_phase == M_DONE));
            if (m_phase == M_DONE || m_fresh == 1) begin
                chk("mdl_res_n", longint'(res_n), longint'(m_n));
                chk("mdl_res_exact", longint'(res_exact), longint'(m_x));
            end
        end
    end

    // One transaction with literal expectations; exp_cyc counts the handshake cycle as 0.
    task automatic run_txn(input logic [15:0] v, input int exp_n, input int exp_x,
                           input int exp_cyc, input int hold);
        int w;
        int cyc;
        @(negedge clk);
        in_value  = v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("latency_v%0d", v), cyc, exp_cyc);
        chk($sformatf("res_n_v%0d", v), longint'(res_n), exp_n);
        chk($sformatf("res_exact_v%0d", v), longint'(res_exact), exp_x);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_value = 16'd6;
            @(negedge clk);
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_res_n", longint'(res_n), exp_n);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", longint'(out_valid), 0);
        chk("in_ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_res_n", longint'(res_n), 0);
        chk("rst_res_exact", longint'(res_exact), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);

        run_txn(16'd120,   5, 1, 6, 0);
        run_txn(16'd1,     1, 1, 2, 0);
        run_txn(16'd40320, 8, 1, 9, 0);
        run_txn(16'd0,     0, 0, 2, 0);
        run_txn(16'd100,   F100, 0, 6, 0);
        run_txn(16'd65535, F65535, 0, 10, 0);
        run_txn(16'd3,     F3, 0, 4, 0);
        run_txn(16'd720,   6, 1, 7, 10);

        // Reset in the middle of computing 7!.
        @(negedge clk);
        in_value = 16'd5040;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_res_n", longint'(res_n), 0);
        chk("midrst_res_exact", longint'(res_exact), 0);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_idle", longint'(out_valid), 0);

        run_txn(16'd6, 3, 1, 4, 0);
        run_txn(16'd2, 2, 1, 3, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_inverse_factorial_seq
